// File: rtl/effect_frame_sequencer.sv
// Initiator side of the effect START/DONE frame handshake: buffers codec samples,
// runs each through one effect core (or bypasses it) and strobes the result out.
`timescale 1ns/1ps
module effect_frame_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        adc_valid,
    input  logic [15:0] adc_frame,
    input  logic        bypass,
    output logic        START,
    output logic [15:0] input_frame,
    input  logic        DONE,
    input  logic [15:0] output_frame,
    output logic        dac_valid,
    output logic [15:0] dac_frame,
    output logic        busy,
    output logic        overflow,
    output logic        timeout_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_EMIT
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [15:0] r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic [WW-1:0] r_wd;
    logic [15:0] r_input_frame;
    logic [15:0] r_dac_frame;
    logic        r_overflow;
    logic        r_timeout_err;

    logic        w_empty;
    logic        w_full;
    logic        w_pop;
    logic        w_push;
    logic        w_drop;
    logic [15:0] w_head;
    logic        w_wd_expire;
    logic        w_wd_fire;
    logic        w_result_load;
    logic [15:0] w_result;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                         (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop       = (r_state == S_IDLE) && !w_empty;
    assign w_push      = adc_valid && (!w_full || w_pop);
    assign w_drop      = adc_valid && w_full && !w_pop;
    assign w_head      = r_mem[r_rd_ptr[AW-1:0]];
    assign w_wd_expire = (r_wd == WW'(TIMEOUT - 1));

    always_comb begin
        w_state_next  = r_state;
        w_result_load = 1'b0;
        w_result      = r_dac_frame;
        w_wd_fire     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    if (bypass) begin
                        w_state_next  = S_EMIT;
                        w_result_load = 1'b1;
                        w_result      = w_head;
                    end else begin
                        w_state_next = S_ISSUE;
                    end
                end
            end
            S_ISSUE: w_state_next = S_WAIT;
            S_WAIT: begin
                // DONE takes priority over a watchdog expiry in the same cycle.
                if (DONE) begin
                    w_state_next  = S_EMIT;
                    w_result_load = 1'b1;
                    w_result      = output_frame;
                end else if (w_wd_expire) begin
                    w_state_next  = S_EMIT;
                    w_result_load = 1'b1;
                    w_result      = r_input_frame;
                    w_wd_fire     = 1'b1;
                end
            end
            S_EMIT:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= adc_frame;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state       <= S_IDLE;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_wd          <= '0;
            r_input_frame <= 16'h0000;
            r_dac_frame   <= 16'h0000;
            r_overflow    <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (AW + 1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr      <= r_rd_ptr + (AW + 1)'(1);
                r_input_frame <= w_head;
            end
            if (r_state == S_ISSUE) begin
                r_wd <= '0;
            end else if (r_state == S_WAIT && !DONE) begin
                r_wd <= r_wd + WW'(1);
            end
            if (w_result_load) begin
                r_dac_frame <= w_result;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_wd_fire) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign START       = (r_state == S_ISSUE);
    assign dac_valid   = (r_state == S_EMIT);
    assign busy        = (r_state != S_IDLE) || !w_empty;
    assign input_frame = r_input_frame;
    assign dac_frame   = r_dac_frame;
    assign overflow    = r_overflow;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_effect_frame_sequencer.sv
// Bench for effect_frame_sequencer: an effect-core model answers START with DONE,
// and each dac_valid strobe is matched against a queue of expected results.
`timescale 1ns/1ps
module tb_effect_frame_sequencer;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        adc_valid = 1'b0;
    logic [15:0] adc_frame = 16'h0000;
    logic        bypass = 1'b0;
    logic        START;
    logic [15:0] input_frame;
    logic        DONE;
    logic [15:0] output_frame;
    logic        dac_valid;
    logic [15:0] dac_frame;
    logic        busy;
    logic        overflow;
    logic        timeout_err;

    // Effect model (0 = never answers, 1 = constant result, 2 = negated input)
    int          model_mode = 0;
    int          model_lat = 1;
    logic [15:0] model_const = 16'h0000;
    logic        model_done = 1'b0;
    logic [15:0] model_frame = 16'h0000;
    logic        man_done = 1'b0;
    logic [15:0] man_frame = 16'h0000;

    logic [15:0] sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          dac_cnt = 0;

    assign DONE         = model_done | man_done;
    assign output_frame = man_done ? man_frame : model_frame;

    effect_frame_sequencer #(.DEPTH(4), .TIMEOUT(16)) dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .adc_valid    (adc_valid),
        .adc_frame    (adc_frame),
        .bypass       (bypass),
        .START        (START),
        .input_frame  (input_frame),
        .DONE         (DONE),
        .output_frame (output_frame),
        .dac_valid    (dac_valid),
        .dac_frame    (dac_frame),
        .busy         (busy),
        .overflow     (overflow),
        .timeout_err  (timeout_err)
    );

    always #10 CLK = ~CLK;

    always begin
        @(posedge CLK); #1;
        if (START && model_mode != 0) begin
            for (int i = 0; i < model_lat; i++) begin
                @(posedge CLK); #1;
            end
            model_frame = (model_mode == 2) ? -input_frame : model_const;
            model_done  = 1'b1;
            @(posedge CLK); #1;
            model_done  = 1'b0;
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "global timeout");
    end

    // Advance one cycle; any dac_valid strobe is scored against the queue head.
    task automatic tick();
        logic [15:0] exp_v;
        @(posedge CLK); #1;
        if (dac_valid) begin
            dac_cnt++;
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: dac_valid with dac_frame=%h, required no output", dac_frame);
            end else begin
                exp_v = sb.pop_front();
                if (dac_frame !== exp_v) begin
                    n_err++;
                    $display("FAIL sb_dac_frame: got %h, required %h", dac_frame, exp_v);
                end
            end
            $display("dac #%0d: dac_frame=%h", dac_cnt, dac_frame);
        end
    endtask

    task automatic drain(input int limit, input string name);
        int i;
        i = 0;
        while ((sb.size() != 0 || busy) && i < limit) begin
            tick();
            i++;
        end
        n_cmp++;
        if (sb.size() != 0 || busy) begin
            n_err++;
            $display("FAIL %s_drain: %0d results pending busy=%b after %0d cycles, required 0", name, sb.size(), busy, limit);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick(); tick();
        Reset = 1'b0;
        n_cmp += 7;
        if (START !== 1'b0)        begin n_err++; $display("FAIL rst_start: got %b, required 0", START); end
        if (dac_valid !== 1'b0)    begin n_err++; $display("FAIL rst_dac_valid: got %b, required 0", dac_valid); end
        if (busy !== 1'b0)         begin n_err++; $display("FAIL rst_busy: got %b, required 0", busy); end
        if (overflow !== 1'b0)     begin n_err++; $display("FAIL rst_overflow: got %b, required 0", overflow); end
        if (timeout_err !== 1'b0)  begin n_err++; $display("FAIL rst_timeout_err: got %b, required 0", timeout_err); end
        if (input_frame !== 16'h0) begin n_err++; $display("FAIL rst_input_frame: got %h, required 0000", input_frame); end
        if (dac_frame !== 16'h0)   begin n_err++; $display("FAIL rst_dac_frame: got %h, required 0000", dac_frame); end
        tick();
    endtask

    task automatic test_single();
        model_mode = 1; model_lat = 1; model_const = 16'h7FFF;
        adc_frame = 16'h3333; adc_valid = 1'b1;
        sb.push_back(16'h7FFF);
        for (int i = 1; i <= 8; i++) begin
            tick();
            adc_valid = 1'b0;
            n_cmp += 2;
            if (START !== (i == 2)) begin n_err++; $display("FAIL single_start c%0d: got %b, required %b", i, START, (i == 2)); end
            if (dac_valid !== (i == 4)) begin n_err++; $display("FAIL single_dac_valid c%0d: got %b, required %b", i, dac_valid, (i == 4)); end
            if (i == 2) begin
                n_cmp++;
                if (input_frame !== 16'h3333) begin n_err++; $display("FAIL single_input_frame: got %h, required 3333", input_frame); end
            end
        end
        n_cmp++;
        if (dac_frame !== 16'h7FFF) begin n_err++; $display("FAIL single_dac_hold: got %h, required 7fff", dac_frame); end
    endtask

    task automatic test_bypass();
        model_mode = 1; model_lat = 1; model_const = 16'hDEAD;
        bypass = 1'b1; adc_frame = 16'h8001; adc_valid = 1'b1;
        sb.push_back(16'h8001);
        for (int i = 1; i <= 6; i++) begin
            tick();
            adc_valid = 1'b0;
            if (i == 2) bypass = 1'b0;
            n_cmp += 2;
            if (START !== 1'b0) begin n_err++; $display("FAIL bypass_start c%0d: got %b, required 0", i, START); end
            if (dac_valid !== (i == 2)) begin n_err++; $display("FAIL bypass_dac_valid c%0d: got %b, required %b", i, dac_valid, (i == 2)); end
        end
    endtask

    // Measures START-to-dac_valid distance with the model at the given setting.
    task automatic test_watchdog(input int mode, input logic [15:0] smp, input logic [15:0] res, input logic exp_to, input string name);
        int start_c;
        int dv_c;
        start_c = -1; dv_c = -1;
        model_mode = mode; model_lat = 16; model_const = res;
        adc_frame = smp; adc_valid = 1'b1;
        sb.push_back(exp_to ? smp : res);
        for (int i = 1; i <= 40; i++) begin
            tick();
            adc_valid = 1'b0;
            if (START && start_c < 0) start_c = i;
            if (dac_valid && dv_c < 0) dv_c = i;
        end
        n_cmp += 3;
        if (start_c != 2) begin n_err++; $display("FAIL %s_start_cycle: got %0d, required 2", name, start_c); end
        if (dv_c - start_c != 17) begin n_err++; $display("FAIL %s_latency: got %0d, required 17", name, dv_c - start_c); end
        if (timeout_err !== exp_to) begin n_err++; $display("FAIL %s_timeout_err: got %b, required %b", name, timeout_err, exp_to); end
    endtask

    task automatic test_overflow();
        logic [15:0] vals [6];
        int base;
        vals = '{16'h1001, 16'h1002, 16'h1003, 16'h1004, 16'h1005, 16'h1006};
        model_mode = 0;
        base = dac_cnt;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) begin
                n_cmp++;
                if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_early: got %b, required 0", overflow); end
            end
            adc_frame = vals[i]; adc_valid = 1'b1;
            if (i < 5) sb.push_back(vals[i]);
            tick();
        end
        adc_valid = 1'b0;
        n_cmp++;
        if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b, required 1", overflow); end
        drain(400, "ovf");
        n_cmp += 3;
        if (dac_cnt - base != 5) begin n_err++; $display("FAIL ovf_count: got %0d, required 5", dac_cnt - base); end
        if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b, required 1", overflow); end
        if (timeout_err !== 1'b1) begin n_err++; $display("FAIL ovf_timeout_err: got %b, required 1", timeout_err); end
    endtask

    task automatic test_reset_mid_wait();
        int base;
        model_mode = 0;
        adc_frame = 16'h4444; adc_valid = 1'b1;
        tick();
        adc_valid = 1'b0;
        repeat (4) tick();
        Reset = 1'b1; man_done = 1'b1; man_frame = 16'h6666;
        tick();
        Reset = 1'b0;
        n_cmp += 7;
        if (START !== 1'b0)        begin n_err++; $display("FAIL rmw_start: got %b, required 0", START); end
        if (dac_valid !== 1'b0)    begin n_err++; $display("FAIL rmw_dac_valid: got %b, required 0", dac_valid); end
        if (busy !== 1'b0)         begin n_err++; $display("FAIL rmw_busy: got %b, required 0", busy); end
        if (overflow !== 1'b0)     begin n_err++; $display("FAIL rmw_overflow: got %b, required 0", overflow); end
        if (timeout_err !== 1'b0)  begin n_err++; $display("FAIL rmw_timeout_err: got %b, required 0", timeout_err); end
        if (input_frame !== 16'h0) begin n_err++; $display("FAIL rmw_input_frame: got %h, required 0000", input_frame); end
        if (dac_frame !== 16'h0)   begin n_err++; $display("FAIL rmw_dac_frame: got %h, required 0000", dac_frame); end
        tick();
        man_done = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL rmw_busy_after: got %b, required 0", busy); end
        repeat (5) tick();
        base = dac_cnt;
        model_mode = 1; model_lat = 2; model_const = 16'h1357;
        adc_frame = 16'h2468; adc_valid = 1'b1;
        sb.push_back(16'h1357);
        tick();
        adc_valid = 1'b0;
        drain(30, "rmw_next");
        n_cmp += 2;
        if (dac_cnt - base != 1) begin n_err++; $display("FAIL rmw_next_count: got %0d, required 1", dac_cnt - base); end
        if (input_frame !== 16'h2468) begin n_err++; $display("FAIL rmw_next_input: got %h, required 2468", input_frame); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] vals [8];
        logic [15:0] neg;
        int base;
        vals = '{16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h1234, 16'hC000, 16'h0F0F, 16'h8001};
        model_mode = 2; model_lat = 2;
        base = dac_cnt;
        for (int i = 0; i < 8; i++) begin
            adc_frame = vals[i]; adc_valid = 1'b1;
            neg = -vals[i];
            sb.push_back(neg);
            tick();
            adc_valid = 1'b0;
            repeat (3) tick();
        end
        drain(100, "b2b");
        n_cmp += 3;
        if (dac_cnt - base != 8) begin n_err++; $display("FAIL b2b_count: got %0d, required 8", dac_cnt - base); end
        if (overflow !== 1'b0) begin n_err++; $display("FAIL b2b_overflow: got %b, required 0", overflow); end
        if (timeout_err !== 1'b0) begin n_err++; $display("FAIL b2b_timeout_err: got %b, required 0", timeout_err); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_bypass();
        test_watchdog(1, 16'h0F0F, 16'h1234, 1'b0, "wd_done16");
        test_watchdog(0, 16'h5A5A, 16'h0000, 1'b1, "wd_expire");
        test_overflow();
        test_reset_mid_wait();
        test_back_to_back();
        n_cmp++;
        if (sb.size() != 0) begin n_err++; $display("FAIL sb_leftover: got %0d pending, required 0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/effect_frame_sequencer.md
Name: effect_frame_sequencer

Overview:
- Initiator side of the effect START/DONE frame handshake.
- Accepts 16-bit signed samples from the codec receive path into a small FIFO.
- Issues each sample to one effect core (e.g. overdrive_effect) with a one-cycle START, waits for DONE, then captures output_frame and presents it to the codec transmit path with a one-cycle valid strobe.
- Provides bypass and a DONE watchdog so a hung effect never stalls the audio stream.

Parameters:
DEPTH, 4, input FIFO depth in samples; power of 2, at least 2.
TIMEOUT, 1024, WAIT cycles without DONE before the sample is forwarded unprocessed.

Ports:
CLK  in  1  system clock, 50 MHz
Reset  in  1  synchronous, active-high reset
adc_valid  in  1  one-cycle strobe: adc_frame holds a new sample
adc_frame  in  16  signed input sample
bypass  in  1  forward samples unprocessed; sampled only at FIFO pop
START  out  1  one-cycle request to the effect core
input_frame  out  16  signed sample to the effect; stable from ISSUE until next pop
DONE  in  1  effect completion strobe
output_frame  in  16  signed effect result; valid when DONE=1
dac_valid  out  1  one-cycle strobe: dac_frame updated
dac_frame  out  16  signed result; held between strobes
busy  out  1  high whenever state is not IDLE or FIFO is non-empty
overflow  out  1  sticky: a sample was dropped on a full FIFO
timeout_err  out  1  sticky: watchdog fired at least once

Behaviour:
- Reset, synchronous and active-high:
  - FIFO emptied; state IDLE; watchdog counter cleared.
  - START, dac_valid, busy, overflow and timeout_err are 0.
  - input_frame and dac_frame are 16'h0000.
  - Reset mid-transaction abandons it: START low next cycle, the in-flight sample is lost, and any DONE during or after reset is ignored.
- FIFO:
  - Push on adc_valid when not full, or when full with a pop in the same cycle.
  - adc_valid while full with no pop: the sample is dropped and overflow is set.
  - Pop happens only in IDLE when the FIFO is non-empty. Order is strict FIFO.
  - A pushed sample is visible to IDLE no earlier than the next cycle; there is no fall-through.
- State machine:
  - IDLE: if the FIFO is non-empty, pop the head into input_frame. If bypass=1, set result = head and go to EMIT; otherwise go to ISSUE. Empty FIFO: stay in IDLE.
  - ISSUE: START=1 for exactly this cycle; clear the watchdog; go to WAIT. DONE during ISSUE is ignored.
  - WAIT: if DONE=1, result = output_frame, go to EMIT. Otherwise increment the watchdog. If this is the TIMEOUT-th WAIT cycle without DONE, result = input_frame, set timeout_err, go to EMIT. DONE wins if it coincides with the timeout cycle.
  - EMIT: dac_frame <= result; dac_valid=1 for this cycle only; go to IDLE.
- Arithmetic: no arithmetic; all data is passed through bit-exact.
- DONE outside WAIT is ignored. START is never re-asserted before DONE or timeout closes the current transaction.
- Latency, with an empty FIFO, an idle FSM and adc_valid in cycle 0:
  - Effect path: START in cycle 2. With DONE in cycle 2+k (k ≥ 1), dac_valid is in cycle 3+k. Minimum is cycle 4.
  - Bypass path: dac_valid in cycle 2.
- Throughput: one sample per (k+3) cycles, which is far above a 48 kHz frame rate.

Test Plan:
- Single sample: adc_frame=16'h3333 in cycle 0; model DONE in cycle 3 with output_frame=16'h7FFF -> START high only in cycle 2, input_frame=16'h3333, dac_valid only in cycle 4, dac_frame=16'h7FFF held afterwards.
- Bypass: bypass=1, adc_frame=16'h8001 -> no START, dac_valid in cycle 2 with dac_frame=16'h8001.
- Overflow: DONE held low (TIMEOUT=16), push 6 samples on consecutive cycles with DEPTH=4 -> first popped immediately, next 4 queued, sixth dropped, overflow=1; after timeouts the outputs emerge in order, unprocessed.
- Watchdog: DONE never asserted, TIMEOUT=16 -> dac_valid exactly 17 cycles after START with dac_frame=input_frame, timeout_err=1; DONE arriving on the 16th WAIT cycle instead -> result = output_frame, timeout_err stays 0.
- Reset mid-WAIT: Reset during WAIT, then DONE pulse -> no dac_valid, all outputs zero, FIFO empty; the next sample processes normally.
- Back-to-back streaming: 8 samples with effect output = input negated -> 8 dac_valid strobes in order with correct values, no overflow.
